// File: rtl/divisor_restauracion.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Optional macro DIVISOR_RESTO_EUCLIDEO_EN selects a Euclidean (non-negative) remainder.
module divisor_restauracion #(
  parameter int NUM_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*NUM_BITS-1:0]   dividendo,
  input  logic [NUM_BITS-1:0]     divisor,
  output logic [NUM_BITS-1:0]     cociente,
  output logic [NUM_BITS-1:0]     resto,
  output logic                    overflow,
  output logic                    Fin
);

  localparam int N  = NUM_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    AJUSTE = 2'd2,
    FIN    = 2'd3
  } state_t;

  function automatic logic [2*N-1:0] abs_dividendo(input logic [2*N-1:0] v);
    return v[2*N-1] ? (~v + {{(2*N-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [N-1:0] abs_divisor(input logic [N-1:0] v);
    return v[N-1] ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      r_q, r_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic            sd_q, sd_d;
  logic            sv_q, sv_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [N-1:0]    cociente_q, cociente_d;
  logic [N-1:0]    resto_q, resto_d;
  logic            overflow_q, overflow_d;
  logic            fin_q, fin_d;

  logic [2*N-1:0]  dvd_mag_s;
  logic [N-1:0]    dvs_mag_s;
  logic [N:0]      r_sh_s;
  logic [N+1:0]    t_s;
  logic            keep_s;
  logic [N:0]      qmag_s;
  logic [N-1:0]    rmag_s;
  logic            qneg_s;
  logic            rneg_s;
  logic            range_ovf_s;

  // Operand magnitudes and one restoring iteration step
  always_comb begin
    dvd_mag_s = abs_dividendo(dividendo);
    dvs_mag_s = abs_divisor(divisor);
    r_sh_s    = {r_q[N-1:0], q_q[N-1]};
    t_s       = {1'b0, r_sh_s} - {2'b00, dvs_q};
    // A set R MSB means the shifted remainder already exceeds any divisor
    keep_s    = r_q[N] | ~t_s[N+1];
  end

  // Sign correction and range check for the AJUSTE cycle
  always_comb begin
    qmag_s = {1'b0, q_q};
    rmag_s = r_q[N-1:0];
    qneg_s = sd_q ^ sv_q;
    rneg_s = sd_q;
`ifdef DIVISOR_RESTO_EUCLIDEO_EN
    if (sd_q && (rmag_s != {N{1'b0}})) begin
      qmag_s = {1'b0, q_q} + {{N{1'b0}}, 1'b1};
      rmag_s = dvs_q - r_q[N-1:0];
      rneg_s = 1'b0;
    end else begin
      rneg_s = sd_q;
    end
`endif
    if (qneg_s) begin
      range_ovf_s = (qmag_s > {2'b01, {(N-1){1'b0}}});
    end else begin
      range_ovf_s = (qmag_s > {2'b00, {(N-1){1'b1}}});
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    dvs_d      = dvs_q;
    sd_d       = sd_q;
    sv_d       = sv_q;
    ovf_pend_d = ovf_pend_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    overflow_d = overflow_q;
    fin_d      = fin_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          r_d        = {1'b0, dvd_mag_s[2*N-1:N]};
          q_d        = dvd_mag_s[N-1:0];
          dvs_d      = dvs_mag_s;
          sd_d       = dividendo[2*N-1];
          sv_d       = divisor[N-1];
          ovf_pend_d = (dvd_mag_s[2*N-1:N] >= dvs_mag_s) || (divisor == {N{1'b0}});
          cnt_d      = {CW{1'b0}};
          fin_d      = 1'b0;
          state_d    = CALC;
        end else begin
          state_d = state_q;
        end
      end
      CALC: begin
        if (keep_s) begin
          r_d = t_s[N:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = r_sh_s;
          q_d = {q_q[N-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = AJUSTE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      AJUSTE: begin
        if (ovf_pend_q || range_ovf_s) begin
          overflow_d = 1'b1;
          cociente_d = {N{1'b0}};
          resto_d    = {N{1'b0}};
        end else begin
          overflow_d = 1'b0;
          cociente_d = qneg_s ? (~qmag_s[N-1:0] + {{(N-1){1'b0}}, 1'b1}) : qmag_s[N-1:0];
          resto_d    = rneg_s ? (~rmag_s + {{(N-1){1'b0}}, 1'b1}) : rmag_s;
        end
        fin_d   = 1'b1;
        state_d = FIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      r_q        <= {(N+1){1'b0}};
      q_q        <= {N{1'b0}};
      dvs_q      <= {N{1'b0}};
      sd_q       <= 1'b0;
      sv_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
      cociente_q <= {N{1'b0}};
      resto_q    <= {N{1'b0}};
      overflow_q <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      dvs_q      <= dvs_d;
      sd_q       <= sd_d;
      sv_q       <= sv_d;
      ovf_pend_q <= ovf_pend_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      overflow_q <= overflow_d;
      fin_q      <= fin_d;
    end
  end

  assign cociente = cociente_q;
  assign resto    = resto_q;
  assign overflow = overflow_q;
  assign Fin      = fin_q;

endmodule

// File: tb/tb_divisor_restauracion.sv
// Directed and exhaustive self-checking bench for divisor_restauracion with NUM_BITS=3.
module tb_divisor_restauracion;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividendo;
  logic [2:0] divisor;
  logic [2:0] cociente;
  logic [2:0] resto;
  logic       overflow;
  logic       Fin;

  int n_cmp;
  int n_err;

  divisor_restauracion #(.NUM_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividendo(dividendo), .divisor(divisor),
    .cociente(cociente), .resto(resto), .overflow(overflow), .Fin(Fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer reference: truncating division, optionally converted to Euclidean
  function automatic void ref_div(input int a, input int b, output int q, output int r, output bit ov);
    if (b == 0) begin
      q = 0; r = 0; ov = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIVISOR_RESTO_EUCLIDEO_EN
      if (r < 0) begin
        r = r + ((b < 0) ? -b : b);
        q = (b > 0) ? q - 1 : q + 1;
      end
`endif
      ov = (q > 3) || (q < -4);
      if (ov) begin
        q = 0; r = 0;
      end
    end
  endfunction

  // Launch one division and return the number of edges until Fin rises (-1 on timeout)
  task automatic run_op(input logic [5:0] a, input logic [2:0] b, output int lat);
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (Fin === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividendo = 6'd0;
    divisor = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({Fin, overflow, cociente, resto} !== 8'd0) begin
      n_err++;
      $display("FAIL reset: got Fin=%b ovf=%b q=%b r=%b, want all 0", Fin, overflow, cociente, resto);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op(6'd9, 3'd3, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL basic_latency: got %0d edges, want 4", lat);
    end
    n_cmp++;
    if ({overflow, cociente, resto} !== {1'b0, 3'd3, 3'd0}) begin
      n_err++;
      $display("FAIL basic_9_div_3: got ovf=%b q=%b r=%b, want ovf=0 q=011 r=000", overflow, cociente, resto);
    end
  endtask

  task automatic test_signs();
    int lat;
    logic [2:0] eq;
    logic [2:0] er;
`ifdef DIVISOR_RESTO_EUCLIDEO_EN
    eq = 3'b100; er = 3'b001;
`else
    eq = 3'b101; er = 3'b111;
`endif
    run_op(6'b111001, 3'd2, lat);
    n_cmp++;
    if ({lat == 4, overflow, cociente, resto} !== {1'b1, 1'b0, eq, er}) begin
      n_err++;
      $display("FAIL signs_m7_div_2: got lat=%0d ovf=%b q=%b r=%b, want lat=4 ovf=0 q=%b r=%b",
               lat, overflow, cociente, resto, eq, er);
    end
  endtask

  task automatic test_range();
    int lat;
    run_op(6'd16, 3'b100, lat);
    n_cmp++;
    if ({overflow, cociente, resto} !== {1'b0, 3'b100, 3'b000}) begin
      n_err++;
      $display("FAIL range_16_div_m4: got ovf=%b q=%b r=%b, want ovf=0 q=100 r=000", overflow, cociente, resto);
    end
    run_op(6'd12, 3'd3, lat);
    n_cmp++;
    if ({overflow, cociente, resto} !== {1'b1, 3'b000, 3'b000}) begin
      n_err++;
      $display("FAIL range_12_div_3: got ovf=%b q=%b r=%b, want ovf=1 q=000 r=000", overflow, cociente, resto);
    end
    run_op(6'b100000, 3'b100, lat);
    n_cmp++;
    if ({lat == 4, overflow, cociente, resto} !== {1'b1, 1'b1, 3'b000, 3'b000}) begin
      n_err++;
      $display("FAIL range_m32_div_m4: got lat=%0d ovf=%b q=%b r=%b, want lat=4 ovf=1 q=000 r=000",
               lat, overflow, cociente, resto);
    end
  endtask

  task automatic test_div_zero();
    int first;
    int pulses;
    logic prev;
    dividendo = 6'd5;
    divisor   = 3'd0;
    start     = 1'b1;
    @(posedge clk); #1;
    prev = Fin;
    first = -1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) start = 1'b0;
      if (Fin === 1'b1 && prev === 1'b0) begin
        pulses++;
        if (first < 0) first = k;
      end
      prev = Fin;
    end
    n_cmp++;
    if (first !== 4 || pulses !== 1) begin
      n_err++;
      $display("FAIL div_zero_timing: got first Fin at %0d with %0d pulses, want 4 and 1", first, pulses);
    end
    n_cmp++;
    if ({overflow, cociente, resto} !== {1'b1, 3'b000, 3'b000}) begin
      n_err++;
      $display("FAIL div_zero_result: got ovf=%b q=%b r=%b, want ovf=1 q=000 r=000", overflow, cociente, resto);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    dividendo = 6'b111001;
    divisor   = 3'd2;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({Fin, overflow, cociente, resto} !== 8'd0) begin
      n_err++;
      $display("FAIL midop_reset_outputs: got Fin=%b ovf=%b q=%b r=%b, want all 0", Fin, overflow, cociente, resto);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (Fin !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midop_no_fin: got Fin high on %0d cycles, want 0", seen);
    end
    run_op(6'd9, 3'd3, lat);
    n_cmp++;
    if ({lat == 4, overflow, cociente, resto} !== {1'b1, 1'b0, 3'd3, 3'd0}) begin
      n_err++;
      $display("FAIL midop_recover: got lat=%0d ovf=%b q=%b r=%b, want lat=4 ovf=0 q=011 r=000",
               lat, overflow, cociente, resto);
    end
  endtask

  task automatic test_back_to_back_sweep();
    int lat;
    int q;
    int r;
    bit ov;
    int cq;
    int cr;
    int ab;
    logic [5:0] av;
    logic [2:0] bv;
    logic [2:0] eq;
    logic [2:0] er;
    for (int a = -32; a < 32; a++) begin
      for (int b = -4; b < 4; b++) begin
        av = a[5:0];
        bv = b[2:0];
        ref_div(a, b, q, r, ov);
        eq = q[2:0];
        er = r[2:0];
        run_op(av, bv, lat);
        n_cmp++;
        if (lat !== 4 || overflow !== ov || cociente !== eq || resto !== er) begin
          n_err++;
          $display("FAIL sweep %0d/%0d: got lat=%0d ovf=%b q=%b r=%b, want lat=4 ovf=%b q=%b r=%b",
                   a, b, lat, overflow, cociente, resto, ov, eq, er);
        end
        if (!ov) begin
          cq = int'($signed(cociente));
          cr = int'($signed(resto));
          ab = (b < 0) ? -b : b;
          n_cmp++;
          if (cq * b + cr !== a || cr >= ab || cr <= -ab) begin
            n_err++;
            $display("FAIL sweep_identity %0d/%0d: got q=%0d r=%0d, want q*b+r=%0d and |r|<%0d",
                     a, b, cq, cr, a, ab);
          end
        end
      end
    end
  endtask

  task automatic test_round_trip();
    int lat;
    int p;
    logic [5:0] pv;
    logic [2:0] bv;
    logic [2:0] av;
    for (int a = -4; a < 4; a++) begin
      for (int b = -4; b < 4; b++) begin
        if (b != 0) begin
          p  = a * b;
          pv = p[5:0];
          bv = b[2:0];
          av = a[2:0];
          run_op(pv, bv, lat);
          n_cmp++;
          if (lat !== 4 || overflow !== 1'b0 || cociente !== av || resto !== 3'b000) begin
            n_err++;
            $display("FAIL round_trip %0d*%0d: got lat=%0d ovf=%b q=%b r=%b, want lat=4 ovf=0 q=%b r=000",
                     a, b, lat, overflow, cociente, resto, av);
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_signs();
    test_range();
    test_div_zero();
    test_reset_mid_op();
    test_back_to_back_sweep();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
